// File: rtl/calc_pkg.sv
// Shared definitions for the calculator stack sequencer: opcodes, FSM states,
// default operand width and a small opcode helper.
package calc_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NEG = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_G1,
    S_WAIT_B,
    S_EXEC,
    S_MUL,
    S_WRITE,
    S_G2,
    S_WAIT_W,
    S_FIN
  } state_e;

  // Minimum stack depth an opcode needs: NEG works on the top only.
  function automatic logic [1:0] min_depth(op_e op);
    return (op == OP_NEG) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle over WIDTH
// cycles, with a 2*WIDTH-bit {hi, lo} accumulator. done is high during the
// cycle whose closing edge performs the final step.
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum;

  // Partial sum: add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
  end

  // Load operands on start, then shift the accumulator right once per cycle.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q  <= sum[WIDTH:1];
      lo_q  <= {sum[0], lo_q[WIDTH-1:1]};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign result = lo_q;
  assign carry  = |hi_q;
  assign done   = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stack_alu_seq.sv
// Stack ALU sequencer: accepts one command, pops/reads operands from the
// operand stack, computes b OP a (or -a), writes the result back over the
// top, and reports completion with a one-cycle done pulse plus sticky flags.
module stack_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SIZE_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              err_underflow,
  output logic              err_illegal,
  output logic              err_stack,
  output logic              carry,
  output logic              st_push,
  output logic              st_pop,
  output logic              st_replace,
  output logic [WIDTH-1:0]  st_data,
  input  logic [WIDTH-1:0]  st_top,
  input  logic [SIZE_W-1:0] st_size,
  input  logic              st_vld,
  input  logic              st_error
);

  state_e state_q, state_d;
  op_e    op_q;

  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              res_c_q;
  logic [WIDTH:0]    alu_full;
  logic [SIZE_W-1:0] need;
  logic              accept;

  logic pop_d, rep_d, done_d;
  logic set_ill, set_uf, set_se;
  logic latch_a, latch_b, exec_en, write_en, mul_start;

  logic [WIDTH-1:0] mul_result;
  logic             mul_carry, mul_done;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign need    = SIZE_W'(min_depth(op_q));
  assign st_push = 1'b0;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .result  (mul_result),
    .carry   (mul_carry),
    .done    (mul_done)
  );

  // Single-cycle ALU for every op except MUL; bit WIDTH is carry/borrow.
  always_comb begin
    alu_full = '0;
    case (op_q)
      OP_ADD:  alu_full = {1'b0, b_q} + {1'b0, a_q};
      OP_SUB:  alu_full = {1'b0, b_q} - {1'b0, a_q};
      OP_AND:  alu_full = {1'b0, b_q & a_q};
      OP_OR:   alu_full = {1'b0, b_q | a_q};
      OP_XOR:  alu_full = {1'b0, b_q ^ a_q};
      OP_NEG:  alu_full = {1'b0, {WIDTH{1'b0}} - a_q};
      default: alu_full = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle control decode.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    pop_d     = 1'b0;
    rep_d     = 1'b0;
    set_ill   = 1'b0;
    set_uf    = 1'b0;
    set_se    = 1'b0;
    latch_a   = 1'b0;
    latch_b   = 1'b0;
    exec_en   = 1'b0;
    write_en  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (st_vld) begin
          if (op_q == OP_ILL) begin
            set_ill = 1'b1;
            state_d = S_FIN;
          end else if (st_size < need) begin
            set_uf  = 1'b1;
            state_d = S_FIN;
          end else if (op_q == OP_NEG) begin
            latch_a = 1'b1;
            state_d = S_EXEC;
          end else begin
            latch_a = 1'b1;
            pop_d   = 1'b1;
            state_d = S_G1;
          end
        end
      end
      S_G1: begin
        if (st_error) begin
          set_se  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (st_error) begin
          set_se  = 1'b1;
          state_d = S_FIN;
        end else if (st_vld) begin
          latch_b = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = S_MUL;
        end else begin
          exec_en = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_MUL:    if (mul_done) state_d = S_WRITE;
      S_WRITE: begin
        rep_d    = 1'b1;
        write_en = 1'b1;
        state_d  = S_G2;
      end
      S_G2: begin
        if (st_error) set_se = 1'b1;
        state_d = S_FIN;
        if (!st_error) state_d = S_WAIT_W;
      end
      S_WAIT_W: begin
        if (st_error) begin
          set_se  = 1'b1;
          state_d = S_FIN;
        end else if (st_vld) begin
          state_d = S_FIN;
        end
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    done_d = (state_d == S_FIN) && (state_q != S_FIN);
  end

  // Registered outputs, operand latches and sticky result flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q          <= OP_ADD;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      res_c_q       <= 1'b0;
      st_data       <= '0;
      st_pop        <= 1'b0;
      st_replace    <= 1'b0;
      done          <= 1'b0;
      carry         <= 1'b0;
      err_underflow <= 1'b0;
      err_illegal   <= 1'b0;
      err_stack     <= 1'b0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
    end else begin
      if (accept) begin
        op_q          <= op_e'(cmd_op);
        carry         <= 1'b0;
        err_underflow <= 1'b0;
        err_illegal   <= 1'b0;
        err_stack     <= 1'b0;
      end
      if (set_ill) err_illegal   <= 1'b1;
      if (set_uf)  err_underflow <= 1'b1;
      if (set_se)  err_stack     <= 1'b1;
      if (latch_a) a_q <= st_top;
      if (latch_b) b_q <= st_top;
      if (exec_en) begin
        res_q   <= alu_full[WIDTH-1:0];
        res_c_q <= alu_full[WIDTH];
      end
      if (write_en) begin
        st_data <= (op_q == OP_MUL) ? mul_result : res_q;
        carry   <= (op_q == OP_MUL) ? mul_carry  : res_c_q;
      end
      st_pop     <= pop_d;
      st_replace <= rep_d;
      done       <= done_d;
      busy       <= (state_d != S_IDLE);
      cmd_ready  <= (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_stack_alu_seq.sv
// Randomized self-checking bench for stack_alu_seq. A queue-based stack model
// answers the pop/replace strobes; expected results, flags, latency and final
// stack contents come from plain arithmetic on the operands.
module tb_stack_alu_seq;

  localparam int WIDTH  = 32;
  localparam int SIZE_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic              cmd_ready, busy, done;
  logic              err_underflow, err_illegal, err_stack, carry;
  logic              st_push, st_pop, st_replace;
  logic [WIDTH-1:0]  st_data;
  logic [WIDTH-1:0]  st_top;
  logic [SIZE_W-1:0] st_size;
  logic              st_vld, st_error;

  stack_alu_seq #(.WIDTH(WIDTH), .SIZE_W(SIZE_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_ready     (cmd_ready),
    .busy          (busy),
    .done          (done),
    .err_underflow (err_underflow),
    .err_illegal   (err_illegal),
    .err_stack     (err_stack),
    .carry         (carry),
    .st_push       (st_push),
    .st_pop        (st_pop),
    .st_replace    (st_replace),
    .st_data       (st_data),
    .st_top        (st_top),
    .st_size       (st_size),
    .st_vld        (st_vld),
    .st_error      (st_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] stk[$];

  // Observations from the most recent command.
  int          o_pop_cnt, o_pop_cyc, o_rep_cnt, o_rep_cyc, o_done_cyc, o_push_cnt;
  logic [31:0] o_rep_data;
  logic        o_seen, o_ready0, o_uf, o_ill, o_se, o_carry;
  logic        o_done_after, o_ready_after, o_uf_after, o_ill_after;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic refresh_stack();
    st_size = SIZE_W'(stk.size());
    st_top  = (stk.size() > 0) ? stk[0] : 32'd0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 2))
      0: return $urandom;
      1: return 32'($urandom_range(0, 15));
      default: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endcase
  endfunction

  // Issue one command (entered #1 after a clock edge with the DUT idle) and
  // play the stack until done, recording everything the DUT drives.
  task automatic run_cmd(input logic [2:0] op, input int stall_pop, input int stall_rep,
                         input int err_cyc);
    int k, left;
    logic p, r;
    logic [31:0] d;
    o_pop_cnt = 0; o_pop_cyc = -1; o_rep_cnt = 0; o_rep_cyc = -1; o_done_cyc = -1;
    o_push_cnt = 0; o_rep_data = '0; o_seen = 1'b0;
    o_uf = 1'b0; o_ill = 1'b0; o_se = 1'b0; o_carry = 1'b0; o_ready0 = 1'b0;
    left = 0;
    st_vld = 1'b1; st_error = 1'b0;
    cmd_valid = 1'b1; cmd_op = op;
    k = 0;
    while (!o_seen && k < 300) begin
      @(negedge clk);
      if (k == 0) o_ready0 = cmd_ready;
      if (st_push) o_push_cnt++;
      if (st_pop) begin o_pop_cnt++; o_pop_cyc = k; end
      if (st_replace) begin o_rep_cnt++; o_rep_cyc = k; o_rep_data = st_data; end
      if (done) begin
        o_seen = 1'b1; o_done_cyc = k;
        o_uf = err_underflow; o_ill = err_illegal; o_se = err_stack; o_carry = carry;
      end
      p = st_pop; r = st_replace; d = st_data;
      @(posedge clk); #1;
      k++;
      cmd_valid = 1'b0;
      if (p && stk.size() > 0) begin void'(stk.pop_front()); left = stall_pop; end
      if (r && stk.size() > 0) begin stk[0] = d; left = stall_rep; end
      refresh_stack();
      st_vld = (left == 0);
      if (left > 0) left--;
      st_error = (k == err_cyc);
    end
    st_error = 1'b0;
    st_vld   = 1'b1;
    @(negedge clk);
    o_done_after = done; o_ready_after = cmd_ready;
    o_uf_after = err_underflow; o_ill_after = err_illegal;
    @(posedge clk); #1;
  endtask

  // Predict the outcome from the stack contents, run the command, compare.
  task automatic run_and_check(input string tag, input logic [2:0] op,
                               input int stall_pop, input int stall_rep);
    logic [31:0] a, b, e_res, exp_stk[$];
    logic [63:0] w;
    logic e_ill, e_uf, e_c, ok, bin;
    int sz, lat;
    sz = stk.size();
    a = (sz > 0) ? stk[0] : 32'd0;
    b = (sz > 1) ? stk[1] : 32'd0;
    e_ill = (op == 3'b111);
    bin   = (op != 3'b110);
    e_uf  = !e_ill && (sz < (bin ? 2 : 1));
    ok    = !e_ill && !e_uf;
    e_res = '0; e_c = 1'b0;
    case (op)
      3'b000: begin w = 64'(b) + 64'(a); e_res = w[31:0]; e_c = w[32]; end
      3'b001: begin e_res = b - a; e_c = (b < a); end
      3'b010: begin w = 64'(b) * 64'(a); e_res = w[31:0]; e_c = (w[63:32] != 0); end
      3'b011: e_res = b & a;
      3'b100: e_res = b | a;
      3'b101: e_res = b ^ a;
      3'b110: e_res = 32'd0 - a;
      default: e_res = '0;
    endcase
    if (!ok)            lat = 2;
    else if (!bin)      lat = 6 + stall_rep;
    else if (op == 3'b010) lat = 8 + WIDTH + stall_pop + stall_rep;
    else                lat = 8 + stall_pop + stall_rep;
    exp_stk = stk;
    if (ok) begin
      if (bin) void'(exp_stk.pop_front());
      exp_stk[0] = e_res;
    end

    run_cmd(op, stall_pop, stall_rep, -1);

    check({tag, " ready_at_accept"}, o_ready0, 1);
    check({tag, " done_seen"}, o_seen, 1);
    check({tag, " done_cycle"}, o_done_cyc, lat);
    check({tag, " err_illegal"}, o_ill, e_ill);
    check({tag, " err_underflow"}, o_uf, e_uf);
    check({tag, " err_stack"}, o_se, 0);
    check({tag, " carry"}, o_carry, ok ? e_c : 1'b0);
    check({tag, " pop_count"}, o_pop_cnt, (ok && bin) ? 1 : 0);
    check({tag, " push_count"}, o_push_cnt, 0);
    check({tag, " replace_count"}, o_rep_cnt, ok ? 1 : 0);
    if (ok && bin) check({tag, " pop_cycle"}, o_pop_cyc, 2);
    if (ok) begin
      check({tag, " replace_cycle"}, o_rep_cyc, lat - 2 - stall_rep);
      check({tag, " st_data"}, o_rep_data, e_res);
    end
    check({tag, " final_size"}, stk.size(), exp_stk.size());
    if (exp_stk.size() > 0) check({tag, " final_top"}, stk[0], exp_stk[0]);
    check({tag, " done_one_pulse"}, o_done_after, 0);
    check({tag, " ready_after"}, o_ready_after, 1);
    check({tag, " underflow_held"}, o_uf_after, e_uf);
    check({tag, " illegal_held"}, o_ill_after, e_ill);
  endtask

  initial begin
    int rep_seen, k;
    logic p;
    logic [2:0] op;
    int sz, sp, sr;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000;
    st_vld = 1'b1; st_error = 1'b0;
    stk = {};
    refresh_stack();
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst strobes", {st_push, st_pop, st_replace}, 0);
    check("rst flags", {err_underflow, err_illegal, err_stack, carry}, 0);
    check("rst st_data", st_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    stk = {32'd7, 32'd5};                 refresh_stack(); run_and_check("add_7_5", 3'b000, 0, 0);
    stk = {32'd10, 32'd3};                refresh_stack(); run_and_check("sub_10_3", 3'b001, 0, 0);
    stk = {32'h0001_0000, 32'h0001_0000}; refresh_stack(); run_and_check("mul_ovf", 3'b010, 0, 0);
    stk = {32'd6, 32'd7};                 refresh_stack(); run_and_check("mul_6_7", 3'b010, 0, 0);
    stk = {32'd9};                        refresh_stack(); run_and_check("add_size1", 3'b000, 0, 0);
    stk = {};                             refresh_stack(); run_and_check("neg_size0", 3'b110, 0, 0);
    stk = {32'd1, 32'd2};                 refresh_stack(); run_and_check("illegal", 3'b111, 0, 0);
    stk = {32'd5, 32'd1};                 refresh_stack(); run_and_check("neg_5", 3'b110, 0, 0);
    stk = {32'h0000_00F0, 32'h0000_003C}; refresh_stack(); run_and_check("xor_stall", 3'b101, 5, 0);
    check("xor_stall done13", o_done_cyc, 13);
    check("xor_stall data_cc", o_rep_data, 32'hCC);

    // Stack error while waiting for the write to settle.
    stk = {32'd7, 32'd5}; refresh_stack();
    run_cmd(3'b000, 0, 0, 7);
    check("se_wait_w done_cycle", o_done_cyc, 8);
    check("se_wait_w err_stack", o_se, 1);
    check("se_wait_w replace_count", o_rep_cnt, 1);

    // Stack error while waiting for operand b: the replace is skipped.
    stk = {32'd7, 32'd5}; refresh_stack();
    run_cmd(3'b000, 0, 0, 3);
    check("se_wait_b done_cycle", o_done_cyc, 4);
    check("se_wait_b err_stack", o_se, 1);
    check("se_wait_b replace_count", o_rep_cnt, 0);
    check("se_wait_b pop_count", o_pop_cnt, 1);

    // Reset in the middle of a multiply.
    stk = {32'd6, 32'd7}; refresh_stack();
    st_vld = 1'b1; st_error = 1'b0;
    cmd_op = 3'b010; cmd_valid = 1'b1;
    rep_seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (st_replace) rep_seen++;
      p = st_pop;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (p && stk.size() > 0) void'(stk.pop_front());
      refresh_stack();
    end
    check("mid_mul busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_mul rst busy", busy, 0);
    check("mid_mul rst strobes", {st_pop, st_replace}, 0);
    check("mid_mul rst done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("mid_mul ready_after", cmd_ready, 1);
    for (k = 0; k < 45; k++) begin
      @(negedge clk);
      if (st_replace) rep_seen++;
    end
    check("mid_mul no_replace", rep_seen, 0);
    @(posedge clk); #1;

    // Randomized commands, stack depths, operands and stalls.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      sz = $urandom_range(0, 4);
      sp = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      sr = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      stk = {};
      for (int j = 0; j < sz; j++) stk.push_back(rnd_val());
      refresh_stack();
      run_and_check($sformatf("rnd%0d_op%0d", i, op), op, sp, sr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
